// File: rtl/reg_dump_uart_if.sv
// ---------------------------------------------------------------------------
// reg_dump_uart_if
//   Signal bundle between a snapshot source and the reg_dump_uart serialiser.
//
//   snapshot_in [128:0]  register snapshot from the core (source -> uart)
//   start                transfer request (source -> uart)
//   tx                   UART serial line, idle high (uart -> board)
//   busy                 frame in progress (uart -> source)
//   done                 one-cycle pulse at end of frame (uart -> source)
//   state_dbg [1:0]      current FSM state, for observation only
//
//   Handshake: start is a request sampled on a rising clk edge; it is taken
//   only when busy is low at that edge, otherwise it is dropped (no queueing).
//   done marks the single cycle where the FSM is back in IDLE.
// ---------------------------------------------------------------------------
interface reg_dump_uart_if;
    logic [128:0] snapshot_in;
    logic         start;
    logic         tx;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    modport master (
        output snapshot_in,
        output start,
        input  tx,
        input  busy,
        input  done,
        input  state_dbg
    );

    modport slave (
        input  snapshot_in,
        input  start,
        output tx,
        output busy,
        output done,
        output state_dbg
    );
endinterface

// File: rtl/reg_dump_uart.sv
// ---------------------------------------------------------------------------
// reg_dump_uart
//   Serialises a 129-bit register snapshot as an 18-byte 8N1 UART frame:
//   SYNC_BYTE followed by {7'b0, snapshot} least-significant byte first.
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//     SYNC_BYTE     header byte sent first
//   Ports
//     clk           system clock
//     rst           asynchronous, active-high reset
//     bus           reg_dump_uart_if slave modport (snapshot_in, start in;
//                   tx, busy, done, state_dbg out)
// ---------------------------------------------------------------------------
module reg_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    reg_dump_uart_if.slave  bus
);

    localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    // The final stop bit hands its last cycle to IDLE, so that the done
    // cycle still shows tx=1 and the frame keeps its 180-bit length while
    // a new start can be accepted in that very cycle.
    localparam logic [15:0] BAUD_SHORT = 16'(CLKS_PER_BIT - 2);
    localparam logic [4:0]  LAST_BYTE  = 5'd17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t       state, state_n;
    logic [15:0]  baud_cnt, baud_n;
    logic [2:0]   bit_idx, bit_n;
    logic [4:0]   byte_idx, byte_n;
    logic [135:0] hold;
    logic         load, shift;
    logic         tx_n, done_n;
    logic [7:0]   cur_byte;
    logic         baud_last, stop_end;

    // Byte 0 is the header; afterwards the hold register is shifted down a
    // byte at the end of each data byte, so its low byte is always current.
    assign cur_byte  = (byte_idx == 5'd0) ? SYNC_BYTE : hold[7:0];
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign stop_end  = (byte_idx == LAST_BYTE) ? (baud_cnt == BAUD_SHORT) : baud_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 5'd0;
            hold     <= 136'd0;
            bus.tx   <= 1'b1;
            bus.done <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            bus.tx   <= tx_n;
            bus.done <= done_n;
            if (load) begin
                hold <= {7'b0, bus.snapshot_in};
            end else if (shift) begin
                hold <= {8'h00, hold[135:8]};
            end
        end
    end

    // tx is computed from the next state so the registered line lines up
    // with the state it belongs to.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        load    = 1'b0;
        shift   = 1'b0;
        tx_n    = 1'b1;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = START;
                    load    = 1'b1;
                    baud_n  = 16'd0;
                    bit_n   = 3'd0;
                    byte_n  = 5'd0;
                    tx_n    = 1'b0;
                end
            end

            START: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    state_n = DATA;
                    baud_n  = 16'd0;
                    bit_n   = 3'd0;
                    tx_n    = cur_byte[0];
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            DATA: begin
                tx_n = cur_byte[bit_idx];
                if (baud_last) begin
                    baud_n = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        bit_n   = 3'd0;
                        tx_n    = 1'b1;
                        shift   = (byte_idx != 5'd0);
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        tx_n  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (stop_end) begin
                    baud_n = 16'd0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                        byte_n  = 5'd0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = START;
                        byte_n  = byte_idx + 5'd1;
                        tx_n    = 1'b0;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_reg_dump_uart.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_uart
//   Bench for reg_dump_uart. A CLKS_PER_BIT=4 instance carries the frame
//   tests; a CLKS_PER_BIT=434 instance checks bit timing on the first bytes.
//   Frame numbering: the accepting edge is N; the negedge after it is
//   cycle 1 (= N+1). A frame spans cycles 1..720, busy in 1..719, done in
//   720 (IDLE, tx=1), and a chained start bit appears in cycle 721.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reg_dump_uart;

    localparam int MC = 4;
    localparam int SC = 434;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst434 = 1'b1;

    reg_dump_uart_if bus4();
    reg_dump_uart_if bus434();

    reg_dump_uart #(.CLKS_PER_BIT(MC), .SYNC_BYTE(8'hA5)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    reg_dump_uart #(.CLKS_PER_BIT(SC), .SYNC_BYTE(8'hA5)) dut434 (
        .clk (clk),
        .rst (rst434),
        .bus (bus434)
    );

    // ---------------- clock / reset -----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard -----------------
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int mon_bytes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [128:0] s);
        logic [135:0] p;
        p = {7'b0, s};
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 17; k++) exp_q.push_back(p[8*k +: 8]);
    endfunction

    // UART decoder on the MC=4 line: samples each bit at its centre.
    initial begin
        bit         act;
        int         cnt;
        logic       prev;
        logic [7:0] sh;
        act = 1'b0; cnt = 0; prev = 1'b1; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0;
                prev = 1'b1;
            end else begin
                if (!act) begin
                    if (prev && !bus4.tx) begin
                        act = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt++;
                    if (cnt == MC/2) check("start_bit", 32'(bus4.tx), 32'd0);
                    for (int j = 1; j <= 8; j++)
                        if (cnt == j*MC + MC/2) sh = {bus4.tx, sh[7:1]};
                    if (cnt == 9*MC + MC/2) begin
                        check("stop_bit", 32'(bus4.tx), 32'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: got %0h expected none", sh);
                        end else begin
                            check("frame_byte", 32'(sh), 32'(exp_q.pop_front()));
                        end
                        mon_bytes++;
                        act = 1'b0;
                    end
                end
                prev = bus4.tx;
            end
        end
    end

    // ---------------- driver tasks -----------------
    task automatic run_frame(input logic [128:0] snap, input bit mutate, input bit poke,
                             output int done_at, output int busy_cyc);
        @(negedge clk);
        bus4.snapshot_in = snap;
        bus4.start = 1'b1;
        push_frame(snap);
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        if (mutate) bus4.snapshot_in = '1;
        done_at = -1;
        busy_cyc = 0;
        for (int i = 1; i <= 800 && done_at < 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("first_tx_low", 32'(bus4.tx), 32'd0);
                check("first_busy", 32'(bus4.busy), 32'd1);
            end
            if (bus4.busy) busy_cyc++;
            if (bus4.done) begin
                done_at = i;
                check("done_busy_low", 32'(bus4.busy), 32'd0);
                check("done_tx_high", 32'(bus4.tx), 32'd1);
            end
            bus4.start = (poke && i == 100);
        end
        bus4.start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- vector table -----------------
    typedef struct {
        logic [128:0] snap;
        bit           mutate;
        bit           poke;
        int           exp_done;
        int           exp_busy;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int done_at, busy_cyc, bad, edges, start_bytes;
        logic prev;
        logic [7:0] hdr;
        logic [128:0] rnd;

        bus4.snapshot_in = '0;
        bus4.start = 1'b0;
        bus434.snapshot_in = '0;
        bus434.start = 1'b0;

        rnd = {$urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom_range(0, 1))};
        vecs[0] = '{129'h1_0000_0000_0000_0000_0000_0000_0000_00FF, 1'b0, 1'b0, 720, 719};
        vecs[1] = '{rnd, 1'b1, 1'b0, 720, 719};
        vecs[2] = '{{129{1'b1}}, 1'b0, 1'b1, 720, 719};
        vecs[3] = '{{1'b0, {16{8'h5A}}}, 1'b1, 1'b1, 720, 719};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus4.tx), 32'd1);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_done", 32'(bus4.done), 32'd0);
        rst = 1'b0;
        idle_cycles(5);

        // reset mid-simulation with no start: line stays quiet
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus4.tx !== 1'b1 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) bad++;
        end
        check("idle_after_rst_bad_cycles", 32'(bad), 32'd0);

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            start_bytes = mon_bytes;
            run_frame(vecs[v].snap, vecs[v].mutate, vecs[v].poke, done_at, busy_cyc);
            check("done_cycle", 32'(done_at), 32'(vecs[v].exp_done));
            check("busy_cycles", 32'(busy_cyc), 32'(vecs[v].exp_busy));
            idle_cycles(50);
            check("no_second_frame_busy", 32'(bus4.busy), 32'd0);
            check("frame_byte_count", 32'(mon_bytes - start_bytes), 32'd18);
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        // back-to-back: start held high through the done cycle
        @(negedge clk);
        bus4.snapshot_in = 129'h0_0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        bus4.start = 1'b1;
        push_frame(bus4.snapshot_in);
        @(posedge clk);
        #1;
        bus4.snapshot_in = 129'h1_F0F0_F0F0_0000_1111_2222_3333_4444_5555;
        done_at = -1;
        for (int i = 1; i <= 800 && done_at < 0; i++) begin
            @(negedge clk);
            if (bus4.done) done_at = i;
        end
        check("b2b_first_done", 32'(done_at), 32'd720);
        push_frame(bus4.snapshot_in);
        @(negedge clk);
        check("b2b_second_start_tx", 32'(bus4.tx), 32'd0);
        check("b2b_second_busy", 32'(bus4.busy), 32'd1);
        bus4.start = 1'b0;
        done_at = -1;
        for (int i = 2; i <= 800 && done_at < 0; i++) begin
            @(negedge clk);
            if (bus4.done) done_at = i;
        end
        check("b2b_second_done", 32'(done_at), 32'd720);
        idle_cycles(10);
        check("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

        // asynchronous reset during byte 5 bit 3 (starts in cycle 213)
        @(negedge clk);
        bus4.snapshot_in = 129'h1_8765_4321_0FED_CBA9_8765_4321_0FED_CBA9;
        bus4.start = 1'b1;
        push_frame(bus4.snapshot_in);
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        repeat (214) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(bus4.tx), 32'd1);
        check("async_rst_busy", 32'(bus4.busy), 32'd0);
        check("async_rst_done", 32'(bus4.done), 32'd0);
        check("async_rst_state", 32'(bus4.state_dbg), 32'd0);
        exp_q.delete();
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(3);
        start_bytes = mon_bytes;
        run_frame(129'h0_DEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 1'b0, 1'b0, done_at, busy_cyc);
        check("post_rst_done", 32'(done_at), 32'd720);
        idle_cycles(10);
        check("post_rst_bytes", 32'(mon_bytes - start_bytes), 32'd18);
        check("post_rst_queue", 32'(exp_q.size()), 32'd0);

        // bit-time accuracy at CLKS_PER_BIT=434, first four bytes
        rst434 = 1'b0;
        idle_cycles(3);
        check("rst434_tx", 32'(bus434.tx), 32'd1);
        @(negedge clk);
        bus434.snapshot_in = 129'h0_0000_0000_0000_0000_0000_0000_0000_C33C;
        bus434.start = 1'b1;
        @(posedge clk);
        #1;
        bus434.start = 1'b0;
        prev = 1'b1;
        hdr = 8'h00;
        edges = 0;
        for (int i = 1; i <= 40*SC; i++) begin
            @(negedge clk);
            if (bus434.tx !== prev) begin
                edges++;
                check("bit_edge_434", 32'((i - 1) % SC), 32'd0);
            end
            prev = bus434.tx;
            if ((i - 1) % SC == SC/2 && (i - 1) / SC >= 1 && (i - 1) / SC <= 8)
                hdr = {bus434.tx, hdr[7:1]};
        end
        check("header_434", 32'(hdr), 32'hA5);
        check("edges_434_seen", 32'(edges > 8), 32'd1);
        rst434 = 1'b1;
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
